// File: rtl/lfsr_ctrl_pkg.sv
// Shared definitions for the LFSR sequencing controller and its core.
package lfsr_ctrl_pkg;

  // Controller FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Operation modes sampled with start.
  localparam logic MODE_RUN  = 1'b0;  // step a programmed number of times
  localparam logic MODE_MEAS = 1'b1;  // step until the seed comes back

  // Default width and feedback mask: x^8+x^6+x^5+x^4+1, period 255.
  localparam int unsigned DEFAULT_N    = 8;
  localparam logic [7:0]  DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: load a seed or step once per enabled cycle.
// Bit k-1 of TAPS selects x^k; the feedback bit enters at the LSB.
module lfsr_core
  import lfsr_ctrl_pkg::*;
#(
  parameter int          N    = DEFAULT_N,
  parameter logic [N-1:0] TAPS = N'(DEFAULT_TAPS)
) (
  input  logic         clk,
  input  logic         rst,   // synchronous, active-low
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] seed,
  output logic [N-1:0] z
);

  logic [N-1:0] r_z;
  logic         w_fb;

  assign w_fb = ^(r_z & TAPS);
  assign z    = r_z;

  // State register: load has priority over a step, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the shift and the feedback see the same old state.
    if (!rst) begin
      r_z <= '0;
    end else if (load) begin
      r_z <= seed;
    end else if (en) begin
      r_z <= {r_z[N-2:0], w_fb};
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller around lfsr_core: seeds the register, then either
// runs a fixed number of steps or measures the period back to the seed.
// Handshake is start/busy/done; every status output is a flop.
module lfsr_seq_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int           N    = DEFAULT_N,
  parameter logic [N-1:0] TAPS = N'(DEFAULT_TAPS)
) (
  input  logic         clk,
  input  logic         rst,      // synchronous, active-low
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] seed,
  input  logic [N-1:0] len,
  output logic [N-1:0] z,
  output logic         out_vld,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] period
);

  // cnt value during the step that would be the (2^N-1)th: no match by then
  // means the taps are singular and the seed never recurs.
  localparam logic [N-1:0] CNT_LAST_STEP = {{(N-1){1'b1}}, 1'b0};

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_mode;
  logic [N-1:0] r_seed;
  logic [N-1:0] r_len;
  logic [N-1:0] r_cnt;
  logic         r_out_vld;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [N-1:0] r_period;

  logic [N-1:0] w_z;
  logic [N-1:0] w_z_next;
  logic [N-1:0] w_cnt_inc;
  logic         w_core_load;
  logic         w_core_en;
  logic         w_accept;
  logic         w_fin_err;
  logic [N-1:0] w_fin_period;

  lfsr_core #(
    .N    (N),
    .TAPS (TAPS)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_core_load),
    .en   (w_core_en),
    .seed (r_seed),
    .z    (w_z)
  );

  // Look-ahead of the core's next state, used for the period match.
  assign w_z_next  = {w_z[N-2:0], ^(w_z & TAPS)};
  assign w_cnt_inc = r_cnt + N'(1);
  assign w_accept  = (r_state == ST_IDLE) && start;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus core controls and completion status.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_nxt  = r_state;
    w_core_load  = 1'b0;
    w_core_en    = 1'b0;
    w_fin_err    = 1'b0;
    w_fin_period = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_core_load = 1'b1;
        if (r_seed == '0) begin
          // Zero is the lockup state; refuse it.
          w_state_nxt = ST_DONE;
          w_fin_err   = 1'b1;
        end else if ((r_mode == MODE_RUN) && (r_len == '0)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_core_en = 1'b1;
        if (r_mode == MODE_RUN) begin
          if (w_cnt_inc == r_len) w_state_nxt = ST_DONE;
        end else if (w_z_next == r_seed) begin
          w_state_nxt  = ST_DONE;
          w_fin_period = w_cnt_inc;
        end else if (r_cnt == CNT_LAST_STEP) begin
          w_state_nxt = ST_DONE;
          w_fin_err   = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, step counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode    <= MODE_RUN;
      r_seed    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_period  <= '0;
    end else begin
      r_busy    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
      r_out_vld <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);

      if (w_accept) begin
        r_mode   <= mode;
        r_seed   <= seed;
        r_len    <= len;
        r_err    <= 1'b0;
        r_period <= '0;
      end

      if (r_state == ST_LOAD) begin
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_cnt <= w_cnt_inc;
      end

      // Result stays put until the next accepted start clears it.
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        r_err    <= w_fin_err;
        r_period <= w_fin_period;
      end
    end
  end

  assign z       = w_z;
  assign out_vld = r_out_vld;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign period  = r_period;

endmodule
